// File: rtl/flash_prog_sequencer.sv
// Bus-write sequencer for a 16-bit NOR flash: issues JEDEC unlock/command cycles,
// then polls RY/BY# with a timeout. All outputs are registered.
module flash_prog_sequencer #(
    parameter int                   SETUP_CYCLES  = 1,
    parameter int                   WE_LOW_CYCLES = 2,
    parameter int                   SETTLE_CYCLES = 4,
    parameter int                   TIMEOUT_W     = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX   = 24'hFFFFFF
) (
    input  logic        CLK_MCU,
    input  logic        nRESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [18:1] CMD_ADDR,
    input  logic [15:0] CMD_DATA,
    output logic [18:1] FL_ADDR,
    output logic [15:0] FL_DATA,
    output logic        FL_DATA_OE,
    output logic        nFLASH_WE,
    output logic        nFLASH_OE,
    input  logic        nFLASH_BUSY,
    output logic        SEQ_DONE,
    output logic        SEQ_ERROR
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_SETTLE, ST_POLL, ST_FINISH
    } state_t;

    localparam logic [7:0]           SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0]           WE_LAST     = 8'(WE_LOW_CYCLES - 1);
    localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TO_LAST     = TIMEOUT_MAX - TIMEOUT_W'(1);

    // Address/data of bus write idx for the given command.
    function automatic logic [33:0] bus_write(input logic [1:0] op, input logic [2:0] idx,
                                              input logic [18:1] addr, input logic [15:0] data);
        logic [33:0] w;
        case (op)
            2'b00: begin
                case (idx)
                    3'd0:    w = {18'h00555, 16'h00AA};
                    3'd1:    w = {18'h002AA, 16'h0055};
                    3'd2:    w = {18'h00555, 16'h00A0};
                    default: w = {addr, data};
                endcase
            end
            2'b01, 2'b10: begin
                case (idx)
                    3'd0, 3'd3: w = {18'h00555, 16'h00AA};
                    3'd1, 3'd4: w = {18'h002AA, 16'h0055};
                    3'd2:       w = {18'h00555, 16'h0080};
                    default:    w = (op == 2'b01) ? {addr, 16'h0030} : {18'h00555, 16'h0010};
                endcase
            end
            default: w = {addr, 16'h00F0};
        endcase
        return w;
    endfunction

    // Index of the final bus write for the given command.
    function automatic logic [2:0] last_idx(input logic [1:0] op);
        logic [2:0] n;
        case (op)
            2'b00:        n = 3'd3;
            2'b01, 2'b10: n = 3'd5;
            default:      n = 3'd0;
        endcase
        return n;
    endfunction

    state_t               state_r, state_s;
    logic [2:0]           idx_r, idx_s;
    logic [7:0]           ph_r, ph_s;
    logic [TIMEOUT_W-1:0] to_r, to_s;
    logic [1:0]           op_r, op_s;
    logic [18:1]          caddr_r, caddr_s;
    logic [15:0]          cdata_r, cdata_s;
    logic                 err_r, err_s;
    logic                 ready_r, ready_s;
    logic                 done_r, done_s;
    logic                 we_n_r, we_n_s;
    logic                 oe_r, oe_s;
    logic [18:1]          fl_addr_r, fl_addr_s;
    logic [15:0]          fl_data_r, fl_data_s;
    logic                 busy_meta_r, busy_sync_r;
    logic                 accept_s;

    assign CMD_READY  = ready_r;
    assign SEQ_DONE   = done_r;
    assign SEQ_ERROR  = err_r;
    assign nFLASH_WE  = we_n_r;
    assign nFLASH_OE  = 1'b1;
    assign FL_DATA_OE = oe_r;
    assign FL_ADDR    = fl_addr_r;
    assign FL_DATA    = fl_data_r;

    // Two-flop synchronizer for RY/BY#; resets to "ready".
    always_ff @(posedge CLK_MCU) begin
        if (!nRESET) begin
            busy_meta_r <= 1'b1;
            busy_sync_r <= 1'b1;
        end else begin
            busy_meta_r <= nFLASH_BUSY;
            busy_sync_r <= busy_meta_r;
        end
    end

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        ph_s     = ph_r;
        to_s     = to_r;
        err_s    = err_r;
        op_s     = op_r;
        caddr_s  = caddr_r;
        cdata_s  = cdata_r;
        accept_s = CMD_VALID & ready_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SETUP;
                    idx_s   = 3'd0;
                    ph_s    = 8'd0;
                    err_s   = 1'b0;
                    op_s    = CMD_OP;
                    caddr_s = CMD_ADDR;
                    cdata_s = CMD_DATA;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (ph_r == SETUP_LAST) begin
                    state_s = ST_STROBE;
                    ph_s    = 8'd0;
                end else begin
                    ph_s = ph_r + 8'd1;
                end
            end
            ST_STROBE: begin
                if (ph_r == WE_LAST) begin
                    state_s = ST_HOLD;
                    ph_s    = 8'd0;
                end else begin
                    ph_s = ph_r + 8'd1;
                end
            end
            ST_HOLD: begin
                if (idx_r != last_idx(op_r)) begin
                    state_s = ST_SETUP;
                    idx_s   = idx_r + 3'd1;
                end else if (op_r == 2'b11) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_SETTLE;
                    ph_s    = 8'd0;
                end
            end
            ST_SETTLE: begin
                to_s = '0;
                if (ph_r == SETTLE_LAST) begin
                    state_s = ST_POLL;
                    ph_s    = 8'd0;
                end else begin
                    ph_s = ph_r + 8'd1;
                end
            end
            ST_POLL: begin
                if (busy_sync_r) begin
                    state_s = ST_FINISH;
                end else if (to_r == TO_LAST) begin
                    state_s = ST_FINISH;
                    to_s    = TIMEOUT_MAX;
                    err_s   = 1'b1;
                end else begin
                    to_s = to_r + TIMEOUT_W'(1);
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase

        ready_s = (state_s == ST_IDLE);
        done_s  = (state_s == ST_FINISH);
        we_n_s  = (state_s != ST_STROBE);
        oe_s    = (state_s == ST_SETUP) || (state_s == ST_STROBE) || (state_s == ST_HOLD);
        // Bus values are loaded in SETUP and then simply held.
        if (state_s == ST_SETUP) begin
            {fl_addr_s, fl_data_s} = bus_write(op_s, idx_s, caddr_s, cdata_s);
        end else begin
            fl_addr_s = fl_addr_r;
            fl_data_s = fl_data_r;
        end
    end

    // State, counters, captured command and output registers.
    always_ff @(posedge CLK_MCU) begin
        if (!nRESET) begin
            state_r   <= ST_IDLE;
            idx_r     <= 3'd0;
            ph_r      <= 8'd0;
            to_r      <= '0;
            op_r      <= 2'b00;
            caddr_r   <= 18'h00000;
            cdata_r   <= 16'h0000;
            err_r     <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            we_n_r    <= 1'b1;
            oe_r      <= 1'b0;
            fl_addr_r <= 18'h00000;
            fl_data_r <= 16'h0000;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            ph_r      <= ph_s;
            to_r      <= to_s;
            op_r      <= op_s;
            caddr_r   <= caddr_s;
            cdata_r   <= cdata_s;
            err_r     <= err_s;
            ready_r   <= ready_s;
            done_r    <= done_s;
            we_n_r    <= we_n_s;
            oe_r      <= oe_s;
            fl_addr_r <= fl_addr_s;
            fl_data_r <= fl_data_s;
        end
    end

endmodule

// File: tb/tb_flash_prog_sequencer.sv
// Randomized bench for flash_prog_sequencer: a bus monitor records every write strobe
// and done pulse; scenario tasks compare them with a command-level model.
module tb_flash_prog_sequencer;

    localparam int S    = 1;
    localparam int L    = 2;
    localparam int SETL = 4;
    localparam int TMAX = 100;
    localparam int WCYC = S + L + 1;

    logic        CLK_MCU = 1'b0;
    logic        nRESET = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_OP = 2'b00;
    logic [18:1] CMD_ADDR = 18'h00000;
    logic [15:0] CMD_DATA = 16'h0000;
    logic [18:1] FL_ADDR;
    logic [15:0] FL_DATA;
    logic        FL_DATA_OE;
    logic        nFLASH_WE;
    logic        nFLASH_OE;
    logic        nFLASH_BUSY = 1'b1;
    logic        SEQ_DONE;
    logic        SEQ_ERROR;

    flash_prog_sequencer #(
        .SETUP_CYCLES(S), .WE_LOW_CYCLES(L), .SETTLE_CYCLES(SETL),
        .TIMEOUT_W(24), .TIMEOUT_MAX(24'd100)
    ) dut (
        .CLK_MCU(CLK_MCU), .nRESET(nRESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .FL_ADDR(FL_ADDR),
        .FL_DATA(FL_DATA), .FL_DATA_OE(FL_DATA_OE), .nFLASH_WE(nFLASH_WE), .nFLASH_OE(nFLASH_OE),
        .nFLASH_BUSY(nFLASH_BUSY), .SEQ_DONE(SEQ_DONE), .SEQ_ERROR(SEQ_ERROR)
    );

    always #5 CLK_MCU = ~CLK_MCU;

    int errors = 0;
    int checks = 0;
    int ncyc = 0;
    int viol = 0;
    int cur_w = 0;
    logic        prev_we = 1'b1;
    logic        prev_oe = 1'b0;
    logic [17:0] prev_addr = 18'h00000;
    logic [15:0] prev_data = 16'h0000;
    logic [17:0] obs_addr[$];
    logic [15:0] obs_data[$];
    int          obs_start[$];
    int          obs_width[$];
    int          done_q[$];
    logic [33:0] exp_q[$];

    // Bus monitor: strobe records plus protocol rule violations.
    always @(negedge CLK_MCU) begin
        ncyc++;
        if (nFLASH_OE !== 1'b1) viol++;
        if (nFLASH_WE === 1'b0) begin
            if (FL_DATA_OE !== 1'b1) viol++;
            if (prev_we) begin
                obs_addr.push_back(FL_ADDR);
                obs_data.push_back(FL_DATA);
                obs_start.push_back(ncyc);
                cur_w = 1;
                if (prev_addr !== FL_ADDR || prev_data !== FL_DATA || prev_oe !== 1'b1) viol++;
            end else begin
                cur_w++;
                if (prev_addr !== FL_ADDR || prev_data !== FL_DATA) viol++;
            end
        end else if (!prev_we) begin
            obs_width.push_back(cur_w);
            if (nRESET && (prev_addr !== FL_ADDR || prev_data !== FL_DATA)) viol++;
        end
        if (SEQ_DONE === 1'b1) done_q.push_back(ncyc);
        prev_we   = nFLASH_WE;
        prev_oe   = FL_DATA_OE;
        prev_addr = FL_ADDR;
        prev_data = FL_DATA;
    end

    task automatic tick();
        @(negedge CLK_MCU);
        #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_start.delete();
        obs_width.delete(); done_q.delete();
    endtask

    // Expected bus writes of one command, built from the JEDEC command tables.
    function automatic void model_writes(input logic [1:0] op, input logic [17:0] a, input logic [15:0] d);
        exp_q.delete();
        if (op == 2'b11) begin
            exp_q.push_back({a, 16'h00F0});
        end else begin
            exp_q.push_back({18'h00555, 16'h00AA});
            exp_q.push_back({18'h002AA, 16'h0055});
            if (op == 2'b00) begin
                exp_q.push_back({18'h00555, 16'h00A0});
                exp_q.push_back({a, d});
            end else begin
                exp_q.push_back({18'h00555, 16'h0080});
                exp_q.push_back({18'h00555, 16'h00AA});
                exp_q.push_back({18'h002AA, 16'h0055});
                exp_q.push_back((op == 2'b01) ? {a, 16'h0030} : {18'h00555, 16'h0010});
            end
        end
    endfunction

    task automatic test_reset();
        nRESET = 1'b0;
        repeat (3) tick();
        checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", CMD_READY); end
        checks++; if (nFLASH_WE !== 1'b1 || nFLASH_OE !== 1'b1) begin errors++; $display("FAIL reset_strobes: got we=%b oe=%b want 1/1", nFLASH_WE, nFLASH_OE); end
        checks++; if (FL_DATA_OE !== 1'b0 || FL_ADDR !== 18'h0 || FL_DATA !== 16'h0) begin errors++; $display("FAIL reset_bus: got oe=%b addr=%h data=%h want 0/0/0", FL_DATA_OE, FL_ADDR, FL_DATA); end
        checks++; if (SEQ_DONE !== 1'b0 || SEQ_ERROR !== 1'b0) begin errors++; $display("FAIL reset_flags: got done=%b err=%b want 0/0", SEQ_DONE, SEQ_ERROR); end
        nRESET = 1'b1;
        tick();
    endtask

    task automatic test_commands();
        for (int it = 0; it < 15; it++) begin
            logic [1:0] op;
            logic [17:0] a;
            logic [15:0] d;
            int rel, n, pe, r, t, acc;
            a = 18'($urandom_range(0, 32'h3FFFF));
            d = 16'($urandom_range(0, 32'hFFFF));
            op = 2'($urandom_range(0, 3));
            rel = $urandom_range(0, 30);
            case (it)
                0: begin op = 2'b00; a = 18'h12345; d = 16'hBEEF; rel = 10; end
                1: begin op = 2'b01; a = 18'h20000; rel = 25; end
                2: op = 2'b11;
                default: ;
            endcase
            model_writes(op, a, d);
            n  = exp_q.size();
            pe = n * WCYC + SETL;
            r  = pe - 4 + rel;
            // Busy released after negedge r: two sync flops plus the POLL decision edge.
            if (op == 2'b11) t = n * WCYC;
            else t = (r + 3 > pe + 1) ? r + 3 : pe + 1;

            tick();
            checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL cmd%0d_ready_idle: got %b want 1", it, CMD_READY); end
            CMD_VALID = 1'b1; CMD_OP = op; CMD_ADDR = a; CMD_DATA = d;
            clear_obs();
            viol = 0;
            tick();
            acc = ncyc;
            CMD_VALID = 1'b0;
            CMD_DATA = ~d;
            nFLASH_BUSY = 1'b0;
            checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL cmd%0d_ready_busy: got %b want 0", it, CMD_READY); end
            while (ncyc < acc + t + 4) begin
                tick();
                if (ncyc == acc + r) nFLASH_BUSY = 1'b1;
            end
            nFLASH_BUSY = 1'b1;

            checks++; if (obs_addr.size() != n || obs_width.size() != n) begin errors++; $display("FAIL cmd%0d_write_count: got %0d want %0d", it, obs_addr.size(), n); end
            for (int w = 0; w < n; w++) begin
                if (w < obs_addr.size() && w < obs_width.size()) begin
                    checks++; if ({obs_addr[w], obs_data[w]} !== exp_q[w]) begin errors++; $display("FAIL cmd%0d_write%0d: got %h/%h want %h/%h", it, w, obs_addr[w], obs_data[w], exp_q[w][33:16], exp_q[w][15:0]); end
                    checks++; if (obs_start[w] != acc + w * WCYC + S || obs_width[w] != L) begin errors++; $display("FAIL cmd%0d_strobe%0d: got start=%0d width=%0d want %0d/%0d", it, w, obs_start[w] - acc, obs_width[w], w * WCYC + S, L); end
                end
            end
            checks++; if (done_q.size() != 1 || done_q[0] != acc + t) begin errors++; $display("FAIL cmd%0d_done: got %0d pulses first at %0d want 1 at %0d", it, done_q.size(), (done_q.size() > 0) ? done_q[0] - acc : -1, t); end
            checks++; if (SEQ_ERROR !== 1'b0 || viol != 0) begin errors++; $display("FAIL cmd%0d_err_viol: got err=%b viol=%0d want 0/0", it, SEQ_ERROR, viol); end
        end
    endtask

    task automatic test_timeout();
        int acc, t;
        t = 4 * WCYC + SETL + TMAX;
        tick();
        CMD_VALID = 1'b1; CMD_OP = 2'b00;
        CMD_ADDR = 18'($urandom_range(0, 32'h3FFFF)); CMD_DATA = 16'($urandom_range(0, 32'hFFFF));
        clear_obs();
        tick();
        acc = ncyc;
        CMD_VALID = 1'b0;
        nFLASH_BUSY = 1'b0;
        while (ncyc < acc + t + 4) begin
            tick();
            if (ncyc == acc + t - 1) begin
                checks++; if (SEQ_ERROR !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", SEQ_ERROR); end
            end
            if (ncyc == acc + t) begin
                checks++; if (SEQ_ERROR !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", SEQ_ERROR); end
            end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != acc + t) begin errors++; $display("FAIL timeout_done: got %0d pulses first at %0d want 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] - acc : -1, t); end
        repeat (3) tick();
        checks++; if (SEQ_ERROR !== 1'b1 || CMD_READY !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got err=%b ready=%b want 1/1", SEQ_ERROR, CMD_READY); end
        CMD_VALID = 1'b1; CMD_OP = 2'b11;
        tick();
        CMD_VALID = 1'b0;
        checks++; if (SEQ_ERROR !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", SEQ_ERROR); end
        nFLASH_BUSY = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        int acc;
        tick();
        CMD_VALID = 1'b1; CMD_OP = 2'b00; CMD_ADDR = 18'h3A5A5; CMD_DATA = 16'h5A5A;
        tick();
        acc = ncyc;
        CMD_VALID = 1'b0;
        while (ncyc < acc + WCYC + S) tick();
        checks++; if (nFLASH_WE !== 1'b0) begin errors++; $display("FAIL rstmid_in_strobe: got %b want 0", nFLASH_WE); end
        nRESET = 1'b0;
        tick();
        checks++; if (nFLASH_WE !== 1'b1 || CMD_READY !== 1'b1 || SEQ_DONE !== 1'b0) begin errors++; $display("FAIL rstmid_abort: got we=%b ready=%b done=%b want 1/1/0", nFLASH_WE, CMD_READY, SEQ_DONE); end
        checks++; if (FL_DATA_OE !== 1'b0 || FL_ADDR !== 18'h0 || FL_DATA !== 16'h0) begin errors++; $display("FAIL rstmid_bus: got oe=%b addr=%h data=%h want 0/0/0", FL_DATA_OE, FL_ADDR, FL_DATA); end
        nRESET = 1'b1;
        clear_obs();
        repeat (40) tick();
        checks++; if (done_q.size() != 0 || obs_addr.size() != 0 || CMD_READY !== 1'b1) begin errors++; $display("FAIL rstmid_quiet: got done=%0d writes=%0d ready=%b want 0/0/1", done_q.size(), obs_addr.size(), CMD_READY); end
    endtask

    task automatic test_valid_held();
        int acc, ready_hi;
        bit seen;
        logic [17:0] a0;
        logic [15:0] d0;
        a0 = 18'($urandom_range(0, 32'h3FFFF));
        d0 = 16'($urandom_range(0, 32'hFFFF));
        model_writes(2'b00, a0, d0);
        ready_hi = 0;
        seen = 1'b0;
        tick();
        CMD_VALID = 1'b1; CMD_OP = 2'b00; CMD_ADDR = a0; CMD_DATA = d0;
        clear_obs();
        tick();
        acc = ncyc;
        for (int k = 0; k < 80 && !seen; k++) begin
            CMD_ADDR = 18'($urandom_range(0, 32'h3FFFF));
            CMD_DATA = 16'($urandom_range(0, 32'hFFFF));
            tick();
            if (SEQ_DONE === 1'b1) begin
                seen = 1'b1;
                CMD_VALID = 1'b0;
            end else if (CMD_READY === 1'b1) begin
                ready_hi++;
            end
        end
        CMD_VALID = 1'b0;
        repeat (10) tick();
        checks++; if (!seen || ready_hi != 0) begin errors++; $display("FAIL held_done: got seen=%b ready_hi=%0d want 1/0", seen, ready_hi); end
        checks++; if (obs_addr.size() != 4 || {obs_addr[3], obs_data[3]} !== exp_q[3]) begin errors++; $display("FAIL held_capture: got %0d writes last %h/%h want 4 last %h/%h", obs_addr.size(), obs_addr[obs_addr.size()-1], obs_data[obs_data.size()-1], a0, d0); end
        checks++; if (done_q.size() != 1 || done_q[0] != acc + 4 * WCYC + SETL + 1) begin errors++; $display("FAIL held_once: got %0d pulses want 1 at %0d", done_q.size(), 4 * WCYC + SETL + 1); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_commands();
        test_timeout();
        test_reset_mid();
        test_valid_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
